link_watchdog: RTL and testbench

LINK_WATCHDOG -- requirements
Module: link_watchdog

---
 rtl/link_watchdog_pkg.sv | 19 +
 rtl/link_watchdog_ch.sv | 99 +++++++++
 rtl/link_watchdog.sv | 73 +++++++
 tb/tb_link_watchdog.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/link_watchdog_pkg.sv
// link_watchdog_pkg: shared channel state encoding and counter sizing for the link watchdog
package link_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_UP,
        ST_RELINK,
        ST_UP,
        ST_FAIL
    } ch_state_e;

    localparam int RETRY_W = 4;
    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : DROP_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/link_watchdog_ch.sv
// link_watchdog_ch: per-channel supervision FSM with relink hold timer, retry and drop counters
module link_watchdog_ch
    import link_watchdog_pkg::*;
#(
    parameter int RST_HOLD = 16384,
    parameter int MAX_RETRY = 8
) (
    input  logic               clk27m_bufg,
    input  logic               rst_gtp,
    input  logic               link_up_s_i,
    input  logic               det_tick_i,
    input  logic               enable_i,
    input  logic               clear_fail_i,
    output logic               serdes_rst_o,
    output logic               link_ok_o,
    output logic               link_fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    ch_state_e          state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [RETRY_W-1:0] retry_q;
    logic [DROP_W-1:0]  drop_q;
    logic               serdes_rst_q;
    logic               link_ok_q;
    logic               link_fail_q;

    // Outputs are updated alongside state_q so they never lag the state by a cycle.
    always_ff @(posedge clk27m_bufg or posedge rst_gtp) begin
        if (rst_gtp) begin
            state_q      <= ST_WAIT_UP;
            hold_q       <= '0;
            retry_q      <= '0;
            drop_q       <= '0;
            serdes_rst_q <= 1'b0;
            link_ok_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else if (!enable_i) begin
            state_q      <= ST_WAIT_UP;
            hold_q       <= '0;
            retry_q      <= '0;
            serdes_rst_q <= 1'b0;
            link_ok_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_UP: begin
                    if (link_up_s_i) begin
                        state_q   <= ST_UP;
                        retry_q   <= '0;
                        link_ok_q <= 1'b1;
                    end else if (det_tick_i && retry_q == RETRY_MAX) begin
                        state_q     <= ST_FAIL;
                        link_fail_q <= 1'b1;
                    end else if (det_tick_i) begin
                        state_q      <= ST_RELINK;
                        retry_q      <= retry_q + 1'b1;
                        hold_q       <= HOLD_LAST;
                        serdes_rst_q <= 1'b1;
                    end
                end
                ST_RELINK: begin
                    if (hold_q == '0) begin
                        state_q      <= ST_WAIT_UP;
                        serdes_rst_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_UP: begin
                    if (!link_up_s_i) begin
                        state_q   <= ST_WAIT_UP;
                        link_ok_q <= 1'b0;
                        drop_q    <= sat_inc(drop_q);
                    end
                end
                default: begin
                    if (clear_fail_i) begin
                        state_q     <= ST_WAIT_UP;
                        retry_q     <= '0;
                        link_fail_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign serdes_rst_o = serdes_rst_q;
    assign link_ok_o    = link_ok_q;
    assign link_fail_o  = link_fail_q;
    assign retry_cnt_o  = retry_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: rtl/link_watchdog.sv
// link_watchdog: input synchronisers, shared link-check period counter and per-channel supervisors
module link_watchdog
    import link_watchdog_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DET_PERIOD = 67108864,
    parameter int RST_HOLD   = 16384,
    parameter int MAX_RETRY  = 8
) (
    input  logic                      clk27m_bufg,
    input  logic                      rst_gtp,
    input  logic [NUM_CH-1:0]         lane_up,
    input  logic [NUM_CH-1:0]         channel_up,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         clear_fail,
    output logic [NUM_CH-1:0]         serdes_rst,
    output logic [NUM_CH-1:0]         link_ok,
    output logic [NUM_CH-1:0]         link_fail,
    output logic [RETRY_W*NUM_CH-1:0] retry_cnt,
    output logic [DROP_W*NUM_CH-1:0]  drop_cnt
);

    localparam int CNT_W = $clog2(DET_PERIOD + 1);

    logic [NUM_CH-1:0] lane_meta_q;
    logic [NUM_CH-1:0] lane_sync_q;
    logic [NUM_CH-1:0] chan_meta_q;
    logic [NUM_CH-1:0] chan_sync_q;
    logic [NUM_CH-1:0] link_up_s;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  period_d;
    logic              det_tick;

    assign det_tick  = period_q == CNT_W'(DET_PERIOD - 1);
    assign period_d  = det_tick ? '0 : period_q + 1'b1;
    assign link_up_s = lane_sync_q & chan_sync_q;

    always_ff @(posedge clk27m_bufg or posedge rst_gtp) begin
        if (rst_gtp) begin
            lane_meta_q <= '0;
            lane_sync_q <= '0;
            chan_meta_q <= '0;
            chan_sync_q <= '0;
            period_q    <= '0;
        end else begin
            lane_meta_q <= lane_up;
            lane_sync_q <= lane_meta_q;
            chan_meta_q <= channel_up;
            chan_sync_q <= chan_meta_q;
            period_q    <= period_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        link_watchdog_ch #(
            .RST_HOLD  (RST_HOLD),
            .MAX_RETRY (MAX_RETRY)
        ) u_ch (
            .clk27m_bufg  (clk27m_bufg),
            .rst_gtp      (rst_gtp),
            .link_up_s_i  (link_up_s[i]),
            .det_tick_i   (det_tick),
            .enable_i     (ch_enable[i]),
            .clear_fail_i (clear_fail[i]),
            .serdes_rst_o (serdes_rst[i]),
            .link_ok_o    (link_ok[i]),
            .link_fail_o  (link_fail[i]),
            .retry_cnt_o  (retry_cnt[RETRY_W*i +: RETRY_W]),
            .drop_cnt_o   (drop_cnt[DROP_W*i +: DROP_W])
        );
    end

endmodule

// File: tb/tb_link_watchdog.sv
// tb_link_watchdog: directed scenarios plus random traffic checked every cycle against a timestamp-based model
module tb_link_watchdog;

    localparam int NUM_CH = 2;
    localparam int DET_PERIOD = 100;
    localparam int RST_HOLD = 10;
    localparam int MAX_RETRY = 3;
    localparam int M_WAIT = 0;
    localparam int M_RELINK = 1;
    localparam int M_UP = 2;
    localparam int M_FAIL = 3;

    logic clk27m_bufg = 1'b0;
    logic rst_gtp = 1'b1;
    logic [NUM_CH-1:0] lane_up = '0;
    logic [NUM_CH-1:0] channel_up = '0;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic [NUM_CH-1:0] clear_fail = '0;
    logic [NUM_CH-1:0] serdes_rst;
    logic [NUM_CH-1:0] link_ok;
    logic [NUM_CH-1:0] link_fail;
    logic [4*NUM_CH-1:0] retry_cnt;
    logic [8*NUM_CH-1:0] drop_cnt;

    int passes = 0;
    int fails = 0;
    int checks = 0;

    // Model: n counts edges since reset release; inputs seen by the FSM are two edges old.
    int n;
    int mode [NUM_CH];
    int retry [NUM_CH];
    int drops [NUM_CH];
    int rl_end [NUM_CH];
    logic [NUM_CH-1:0] p1;
    logic [NUM_CH-1:0] p2;

    always #5 clk27m_bufg = ~clk27m_bufg;

    link_watchdog #(
        .NUM_CH     (NUM_CH),
        .DET_PERIOD (DET_PERIOD),
        .RST_HOLD   (RST_HOLD),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk27m_bufg (clk27m_bufg),
        .rst_gtp     (rst_gtp),
        .lane_up     (lane_up),
        .channel_up  (channel_up),
        .ch_enable   (ch_enable),
        .clear_fail  (clear_fail),
        .serdes_rst  (serdes_rst),
        .link_ok     (link_ok),
        .link_fail   (link_fail),
        .retry_cnt   (retry_cnt),
        .drop_cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        p1 = '0;
        p2 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode[i] = M_WAIT;
            retry[i] = 0;
            drops[i] = 0;
            rl_end[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit tick;
        bit ls;
        n++;
        tick = (n % DET_PERIOD) == 0;
        for (int i = 0; i < NUM_CH; i++) begin
            ls = p2[i];
            if (!ch_enable[i]) begin
                mode[i] = M_WAIT;
                retry[i] = 0;
            end else if (mode[i] == M_WAIT) begin
                if (ls) begin
                    mode[i] = M_UP;
                    retry[i] = 0;
                end else if (tick && retry[i] == MAX_RETRY) begin
                    mode[i] = M_FAIL;
                end else if (tick) begin
                    mode[i] = M_RELINK;
                    retry[i]++;
                    rl_end[i] = n + RST_HOLD;
                end
            end else if (mode[i] == M_RELINK) begin
                if (n == rl_end[i]) mode[i] = M_WAIT;
            end else if (mode[i] == M_UP) begin
                if (!ls) begin
                    mode[i] = M_WAIT;
                    drops[i] = (drops[i] >= 255) ? 255 : drops[i] + 1;
                end
            end else if (clear_fail[i]) begin
                mode[i] = M_WAIT;
                retry[i] = 0;
            end
        end
        p2 = p1;
        p1 = lane_up & channel_up;
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] eo;
        logic [NUM_CH-1:0] ef;
        logic [NUM_CH-1:0] es;
        logic [4*NUM_CH-1:0] er;
        logic [8*NUM_CH-1:0] ed;
        for (int i = 0; i < NUM_CH; i++) begin
            eo[i] = mode[i] == M_UP;
            ef[i] = mode[i] == M_FAIL;
            es[i] = mode[i] == M_RELINK;
            er[4*i +: 4] = 4'(retry[i]);
            ed[8*i +: 8] = 8'(drops[i]);
        end
        check("link_ok", 32'(link_ok), 32'(eo));
        check("link_fail", 32'(link_fail), 32'(ef));
        check("serdes_rst", 32'(serdes_rst), 32'(es));
        check("retry_cnt", 32'(retry_cnt), 32'(er));
        check("drop_cnt", 32'(drop_cnt), 32'(ed));
    endtask

    task automatic cyc();
        @(posedge clk27m_bufg);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int k);
        repeat (k) cyc();
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(posedge clk27m_bufg);
        #1;
        check_all();
        lane_up = 2'b11;
        channel_up = 2'b11;
        ch_enable = 2'b11;
        @(negedge clk27m_bufg);
        rst_gtp = 1'b0;

        // Both links up straight out of reset.
        run(2);
        check("up_early", 32'(link_ok), 32'h0);
        run(1);
        check("up_at_3", 32'(link_ok), 32'h3);

        // Channel 0 held down until it exhausts its retries.
        lane_up[0] = 1'b0;
        run(402);
        check("ch0_failed", 32'(link_fail), 32'h1);
        check("ch1_untouched", 32'(link_ok), 32'h2);
        check("ch0_retry_max", 32'(retry_cnt[3:0]), 32'(MAX_RETRY));

        clear_fail[0] = 1'b1;
        cyc();
        clear_fail[0] = 1'b0;
        check("clear_released", 32'(link_fail), 32'h0);
        check("clear_retry", 32'(retry_cnt[3:0]), 32'h0);
        lane_up[0] = 1'b1;
        run(2);
        check("relink_early", 32'(link_ok), 32'h2);
        run(1);
        check("relink_up", 32'(link_ok), 32'h3);

        // Drop counter saturation on channel 1.
        for (int k = 0; k < 300; k++) begin
            channel_up[1] = 1'b0;
            run(5);
            channel_up[1] = 1'b1;
            run(8);
        end
        check("drop_sat", 32'(drop_cnt[15:8]), 32'hff);
        check("drop_ch0", 32'(drop_cnt[7:0]), 32'h1);

        // Link rising on the same edge as the tick goes UP without a relink.
        ch_enable[1] = 1'b0;
        channel_up[1] = 1'b0;
        run(3);
        while ((n % DET_PERIOD) != DET_PERIOD - 3) cyc();
        ch_enable[1] = 1'b1;
        channel_up[1] = 1'b1;
        run(3);
        check("tie_up", 32'(link_ok[1]), 32'h1);
        check("tie_no_rst", 32'(serdes_rst[1]), 32'h0);
        check("tie_retry", 32'(retry_cnt[7:4]), 32'h0);

        // Disable mid-relink aborts the reset pulse.
        lane_up[0] = 1'b0;
        guard = 0;
        while (!(mode[0] == M_RELINK && n - (rl_end[0] - RST_HOLD) >= 3) && guard < 300) begin
            cyc();
            guard++;
        end
        check("in_relink", 32'(serdes_rst[0]), 32'h1);
        ch_enable[0] = 1'b0;
        cyc();
        check("abort_rst", 32'(serdes_rst[0]), 32'h0);
        check("abort_retry", 32'(retry_cnt[3:0]), 32'h0);
        ch_enable[0] = 1'b1;
        lane_up[0] = 1'b1;
        run(5);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 149) == 0) lane_up[i] = ~lane_up[i];
                if ($urandom_range(0, 24) == 0) channel_up[i] = ~channel_up[i];
                if ($urandom_range(0, 299) == 0) ch_enable[i] = ~ch_enable[i];
                clear_fail[i] = $urandom_range(0, 29) == 0;
            end
            cyc();
        end

        // Asynchronous reset in the middle of a cycle.
        clear_fail = '0;
        @(negedge clk27m_bufg);
        #2;
        rst_gtp = 1'b1;
        #1;
        model_reset();
        check_all();
        ch_enable = 2'b11;
        @(negedge clk27m_bufg);
        rst_gtp = 1'b0;
        run(250);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
